// File: rtl/fft_out_reorder_if.sv
// Stream bundle for fft_out_reorder: FFT-side capture beats in, natural-order
// valid/ready beats out, plus status.
interface fft_out_reorder_if #(
  parameter int WIDTH_OUT = 13,
  parameter int ARRAY_BTF = 16,
  parameter int N_FFT     = 512
);
  localparam int ADDR_W = $clog2(N_FFT);

  logic                        do_en;
  logic signed [WIDTH_OUT-1:0] do_re [0:ARRAY_BTF-1];
  logic signed [WIDTH_OUT-1:0] do_im [0:ARRAY_BTF-1];

  logic                        out_valid;
  logic                        out_ready;
  logic signed [WIDTH_OUT-1:0] out_re [0:ARRAY_BTF-1];
  logic signed [WIDTH_OUT-1:0] out_im [0:ARRAY_BTF-1];
  logic [ADDR_W-1:0]           out_bin_base;
  logic                        out_last;
  logic                        busy;
  logic                        ovf;

  modport master (
    output do_en, do_re, do_im, out_ready,
    input  out_valid, out_re, out_im, out_bin_base, out_last, busy, ovf
  );

  modport slave (
    input  do_en, do_re, do_im, out_ready,
    output out_valid, out_re, out_im, out_bin_base, out_last, busy, ovf
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Captures one bit-reversed FFT frame into a single buffer, then drains it in
// natural bin order over valid/ready, ARRAY_BTF bins per beat.
module fft_out_reorder #(
  parameter int WIDTH_OUT = 13,
  parameter int ARRAY_BTF = 16,
  parameter int N_FFT     = 512
) (
  input logic          clk,
  input logic          rst,
  fft_out_reorder_if.slave bus
);
  localparam int ADDR_W = $clog2(N_FFT);
  localparam int LANE_W = $clog2(ARRAY_BTF);
  localparam int BEAT_W = ADDR_W - LANE_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                  state;
  logic [BEAT_W-1:0]           count;
  logic [BEAT_W-1:0]           rd;
  logic signed [WIDTH_OUT-1:0] mem_re [0:N_FFT-1];
  logic signed [WIDTH_OUT-1:0] mem_im [0:N_FFT-1];

  logic              wr_en;
  logic              ld_en;
  logic [BEAT_W-1:0] ld_beat;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) y[i] = a[ADDR_W-1-i];
    return y;
  endfunction

  // The first drain cycle (out_valid still low) loads beat 0; later loads
  // fetch the beat after the one being accepted.
  always_comb begin
    wr_en   = bus.do_en && (state == IDLE || state == FILL);
    ld_beat = bus.out_valid ? rd + 1'b1 : '0;
    ld_en   = (state == DRAIN) &&
              (!bus.out_valid || (bus.out_ready && rd != LAST_BEAT));
  end

  // count is held at zero in IDLE, so it also addresses beat 0.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int unsigned l = 0; l < ARRAY_BTF; l++) begin
        mem_re[bitrev({count, LANE_W'(l)})] <= bus.do_re[l];
        mem_im[bitrev({count, LANE_W'(l)})] <= bus.do_im[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      rd               <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_last     <= 1'b0;
      bus.out_bin_base <= '0;
      bus.busy         <= 1'b0;
      bus.ovf          <= 1'b0;
      for (int unsigned l = 0; l < ARRAY_BTF; l++) begin
        bus.out_re[l] <= '0;
        bus.out_im[l] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.do_en) begin
            count    <= count + 1'b1;
            state    <= FILL;
            bus.busy <= 1'b1;
          end
        end
        FILL: begin
          if (bus.do_en) begin
            count <= count + 1'b1;
            if (count == LAST_BEAT) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.do_en) bus.ovf <= 1'b1;
          if (bus.out_valid && bus.out_ready && rd == LAST_BEAT) begin
            state         <= IDLE;
            rd            <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (ld_en) begin
        rd               <= ld_beat;
        bus.out_valid    <= 1'b1;
        bus.out_last     <= (ld_beat == LAST_BEAT);
        bus.out_bin_base <= {ld_beat, {LANE_W{1'b0}}};
        for (int unsigned l = 0; l < ARRAY_BTF; l++) begin
          bus.out_re[l] <= mem_re[{ld_beat, LANE_W'(l)}];
          bus.out_im[l] <= mem_im[{ld_beat, LANE_W'(l)}];
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: impulse, ramp, backpressure, gapped
// input, overflow and mid-frame reset.
module tb_fft_out_reorder;
  localparam int W = 13;
  localparam int L = 16;
  localparam int N = 512;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_out_reorder_if #(.WIDTH_OUT(W), .ARRAY_BTF(L), .N_FFT(N)) bus ();

  fft_out_reorder #(.WIDTH_OUT(W), .ARRAY_BTF(L), .N_FFT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int bitrev9(input int k);
    int y = 0;
    for (int i = 0; i < 9; i++) if (k[i]) y |= (1 << (8 - i));
    return y;
  endfunction

  // mode 0: impulse at position 0, mode 1: ramp re=p, im=-p
  function automatic int samp_re(input int mode, input int p);
    return (mode == 0) ? ((p == 0) ? 100 : 0) : p;
  endfunction
  function automatic int samp_im(input int mode, input int p);
    return (mode == 0) ? ((p == 0) ? -50 : 0) : -p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"}, bus.out_valid, 0);
    chk({tag, " last"}, bus.out_last, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " ovf"}, bus.ovf, 0);
    chk({tag, " base"}, bus.out_bin_base, 0);
    for (int l = 0; l < L; l++) begin
      chk($sformatf("%s re l%0d", tag, l), bus.out_re[l], 0);
      chk($sformatf("%s im l%0d", tag, l), bus.out_im[l], 0);
    end
  endtask

  task automatic send_frame(input int mode, input int gap, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < L; l++) begin
        bus.do_re[l] = W'(samp_re(mode, 16 * b + l));
        bus.do_im[l] = W'(samp_im(mode, 16 * b + l));
      end
      bus.do_en = 1'b1;
      tick();
      bus.do_en = 1'b0;
      chk($sformatf("fill busy b%0d", b), bus.busy, 1);
      chk($sformatf("fill valid b%0d", b), bus.out_valid, 0);
      if (b < nbeats - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk($sformatf("gap busy b%0d", b), bus.busy, 1);
        end
      end
    end
  endtask

  // pat 0: ready=1; pat 1: alternating plus a 5-cycle stall at beat 7
  task automatic drain(input int mode, input int pat, input bit inject);
    int hs = 0;
    int cyc = 0;
    int stall = 0;
    bit seen = 0;
    bit rdy;
    bit vld;
    while (hs < 32 && cyc < 300) begin
      vld = bus.out_valid;
      if (vld) begin
        if (!seen) begin
          seen = 1;
          chk("latency", cyc, 1);
        end
        for (int l = 0; l < L; l++) begin
          chk($sformatf("re r%0d l%0d", hs, l), bus.out_re[l], samp_re(mode, bitrev9(16 * hs + l)));
          chk($sformatf("im r%0d l%0d", hs, l), bus.out_im[l], samp_im(mode, bitrev9(16 * hs + l)));
        end
        if (mode == 1 && hs == 0) begin
          chk("ramp l1 re", bus.out_re[1], 256);
          chk("ramp l2 re", bus.out_re[2], 128);
          chk("ramp l3 re", bus.out_re[3], 384);
          chk("ramp l3 im", bus.out_im[3], -384);
        end
        chk($sformatf("base r%0d", hs), bus.out_bin_base, 16 * hs);
        chk($sformatf("last r%0d", hs), bus.out_last, (hs == 31));
        chk($sformatf("drain busy r%0d", hs), bus.busy, 1);
        if (pat == 1 && hs == 7 && stall < 5) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = (pat == 0) ? 1'b1 : (cyc % 2 == 0);
        end
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      bus.out_ready = rdy;
      if (inject && vld && (hs == 10 || hs == 31)) begin
        for (int l = 0; l < L; l++) begin
          bus.do_re[l] = 13'sd7;
          bus.do_im[l] = 13'sd7;
        end
        bus.do_en = 1'b1;
      end
      tick();
      bus.do_en = 1'b0;
      if (vld && rdy) hs++;
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("handshakes", hs, 32);
    chk("post valid", bus.out_valid, 0);
    chk("post busy", bus.busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.do_en = 1'b0;
    bus.out_ready = 1'b0;
    for (int l = 0; l < L; l++) begin
      bus.do_re[l] = '0;
      bus.do_im[l] = '0;
    end
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    send_frame(0, 0, 32);
    drain(0, 0, 0);

    send_frame(1, 0, 32);
    drain(1, 0, 0);

    send_frame(1, 0, 32);
    drain(1, 1, 0);

    send_frame(1, 3, 32);
    drain(1, 0, 0);

    chk("ovf before", bus.ovf, 0);
    send_frame(1, 0, 32);
    drain(1, 0, 1);
    chk("ovf set", bus.ovf, 1);
    tick();
    send_frame(0, 0, 32);
    drain(0, 0, 0);
    chk("ovf sticky", bus.ovf, 1);

    send_frame(1, 0, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midreset");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midreset idle valid", bus.out_valid, 0);
    end
    send_frame(1, 0, 32);
    drain(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
